// File: rtl/uart_tx_cfg_pkg.sv
// Shared UART transmit types, line levels and helpers.
// Used by the transmitter top and its baud counter.
package uart_tx_cfg_pkg;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam int   UART_MIN_DATA_BITS = 5;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    EVEN = 2'b01,
    ODD  = 2'b10,
    RSVD = 2'b11
  } uart_parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  // Clamp requested data bits into MIN..max_bits.
  function automatic logic [3:0] clamp_bits(
    input logic [3:0] req,
    input logic [3:0] max_bits
  );
    if (req < 4'(UART_MIN_DATA_BITS))
      return 4'(UART_MIN_DATA_BITS);
    else if (req > max_bits)
      return max_bits;
    return req;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_baud.sv
// Bit-period counter: counts the divisor down to zero.
// Ports: i_load reloads from i_div, i_en counts, o_bit_end ticks.
module uart_baud_cnt #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_en,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_bit_end
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_div;

  // Divisor is captured on load so later i_div changes
  // do not disturb the frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_div <= '0;
    end else if (i_load) begin
      r_cnt <= i_div;
      r_div <= i_div;
    end else if (i_en) begin
      if (r_cnt == '0)
        r_cnt <= r_div;
      else
        r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_bit_end = i_en & (r_cnt == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// Run-time configurable UART transmitter (5..9N/E/O 1/2).
// Ports: cfg_* frame setup, s_* word handshake, tx/busy/frame_done.
module uart_tx_cfg
  import uart_tx_cfg_pkg::*;
#(
  parameter int DATA_WIDTH_MAX = 9,
  parameter int DIV_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DIV_WIDTH-1:0]      cfg_div,
  input  logic [3:0]                cfg_data_bits,
  input  logic [1:0]                cfg_parity,
  input  logic                      cfg_stop2,
  input  logic [DATA_WIDTH_MAX-1:0] s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic                      tx,
  output logic                      busy,
  output logic                      frame_done
);

  uart_tx_state_e            r_state;
  logic                      r_tx;
  logic [DATA_WIDTH_MAX-1:0] r_shift;
  logic [3:0]                r_nbits;
  logic [3:0]                r_bit_cnt;
  logic                      r_par_en;
  logic                      r_par_bit;
  logic                      r_stop2;
  logic                      r_stop_cnt;

  logic                      w_bit_end;
  logic                      w_accept;
  logic                      w_busy;
  logic                      w_last_stop;
  logic                      w_frame_done;
  logic [3:0]                w_nbits;
  logic [DATA_WIDTH_MAX-1:0] w_mask;
  logic [DATA_WIDTH_MAX-1:0] w_data;
  uart_parity_e              w_par;

  assign w_par   = uart_parity_e'(cfg_parity);
  assign w_nbits = clamp_bits(cfg_data_bits,
                              4'(DATA_WIDTH_MAX));

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DATA_WIDTH_MAX; i++)
      w_mask[i] = (4'(i) < w_nbits);
  end

  assign w_data = s_data & w_mask;

  assign w_busy      = (r_state != IDLE);
  assign w_last_stop = (r_state == STOP) &
                       (~r_stop2 | r_stop_cnt);
  // Frame ends on the last stop tick; the transmitter is
  // ready in that same cycle so frames can abut.
  assign w_frame_done = w_last_stop & w_bit_end & ~rst;

  assign s_ready = ((r_state == IDLE) | w_frame_done)
                   & ~rst;
  assign w_accept = s_valid & s_ready;

  uart_baud_cnt #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_accept),
    .i_en      (w_busy),
    .i_div     (cfg_div),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tx       <= UART_STOP_BIT;
      r_shift    <= '0;
      r_nbits    <= 4'(UART_MIN_DATA_BITS);
      r_bit_cnt  <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
    end else if (w_accept) begin
      r_state    <= START;
      r_tx       <= UART_START_BIT;
      r_shift    <= w_data;
      r_nbits    <= w_nbits;
      r_bit_cnt  <= '0;
      r_par_en   <= (w_par == EVEN) | (w_par == ODD);
      r_par_bit  <= (^w_data) ^ (w_par == ODD);
      r_stop2    <= cfg_stop2;
      r_stop_cnt <= 1'b0;
    end else if (w_bit_end) begin
      case (r_state)
        START: begin
          r_state   <= DATA;
          r_tx      <= r_shift[0];
          r_shift   <= r_shift >> 1;
          r_bit_cnt <= '0;
        end
        DATA: begin
          if (r_bit_cnt == r_nbits - 4'd1) begin
            if (r_par_en) begin
              r_state <= PARITY;
              r_tx    <= r_par_bit;
            end else begin
              r_state <= STOP;
              r_tx    <= UART_STOP_BIT;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
          end
        end
        PARITY: begin
          r_state <= STOP;
          r_tx    <= UART_STOP_BIT;
        end
        STOP: begin
          if (!w_last_stop)
            r_stop_cnt <= 1'b1;
          else
            r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= UART_STOP_BIT;
        end
      endcase
    end
  end

  assign tx         = r_tx;
  assign busy       = w_busy;
  assign frame_done = w_frame_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: frames, clamping,
// back-to-back handoff and mid-frame reset.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_div;
  logic [3:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic [8:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        tx;
  logic        busy;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(
    .DATA_WIDTH_MAX (9),
    .DIV_WIDTH      (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_div       (cfg_div),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .tx            (tx),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!s_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ready_wait", 32'(s_ready), 32'd1);
  endtask

  // Returns after the accepting edge, at cycle 1 sample point.
  task automatic send(input logic [8:0] d);
    s_data  = d;
    s_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  // Samples tx at the first cycle of each bit period until
  // frame_done; len is the frame length in cycles.
  task automatic capture(input int div,
                         output logic [15:0] bits,
                         output int len,
                         output int nbusy);
    int k = 1;
    bits  = '0;
    nbusy = 0;
    len   = 0;
    forever begin
      if ((k - 1) % (div + 1) == 0 &&
          (k - 1) / (div + 1) < 16)
        bits[(k - 1) / (div + 1)] = tx;
      if (busy) nbusy++;
      if (frame_done) begin
        len = k;
        break;
      end
      if (k >= 600) break;
      @(posedge clk); #1;
      k++;
    end
  endtask

  logic [15:0] cap;
  int          len;
  int          nb;
  int          pulses;
  int          lows;

  initial begin
    rst           = 1'b1;
    cfg_div       = 16'd3;
    cfg_data_bits = 4'd8;
    cfg_parity    = 2'b00;
    cfg_stop2     = 1'b0;
    s_data        = '0;
    s_valid       = 1'b0;

    @(posedge clk); #1;
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(s_ready), 32'd1);

    // 8N1 div 3
    @(posedge clk); #1;
    send(9'h0A5);
    capture(3, cap, len, nb);
    chk("8n1_bits", 32'(cap), 32'h34A);
    chk("8n1_len", 32'(len), 32'd40);
    chk("8n1_busy", 32'(nb), 32'd40);

    // 7E1 div 1
    cfg_div = 16'd1; cfg_data_bits = 4'd7;
    cfg_parity = 2'b01;
    send(9'h055);
    capture(1, cap, len, nb);
    chk("7e1_bits", 32'(cap), 32'h2AA);
    chk("7e1_len", 32'(len), 32'd20);

    // 7O1, bit 7 set but outside the field
    cfg_parity = 2'b10;
    send(9'h0D5);
    capture(1, cap, len, nb);
    chk("7o1_bits", 32'(cap), 32'h3AA);
    chk("7o1_len", 32'(len), 32'd20);

    // 9O2 div 0
    cfg_div = 16'd0; cfg_data_bits = 4'd9;
    cfg_parity = 2'b10; cfg_stop2 = 1'b1;
    send(9'h1FF);
    capture(0, cap, len, nb);
    chk("9o2_bits", 32'(cap), 32'h1BFE);
    chk("9o2_len", 32'(len), 32'd13);

    // clamp low: 3 -> 5 bits
    cfg_div = 16'd1; cfg_data_bits = 4'd3;
    cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    send(9'h0FF);
    capture(1, cap, len, nb);
    chk("clamp5_bits", 32'(cap), 32'h7E);
    chk("clamp5_len", 32'(len), 32'd14);

    // clamp high: 15 -> 9 bits
    cfg_div = 16'd0; cfg_data_bits = 4'd15;
    send(9'h0F3);
    capture(0, cap, len, nb);
    chk("clamp9_bits", 32'(cap), 32'h5E6);
    chk("clamp9_len", 32'(len), 32'd11);

    // back-to-back with cfg change mid-frame
    cfg_div = 16'd2; cfg_data_bits = 4'd8;
    cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    s_data  = 9'h012;
    s_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    s_data = 9'h034;
    cfg_div = 16'd1; cfg_parity = 2'b01;
    capture(2, cap, len, nb);
    chk("b2b1_bits", 32'(cap), 32'h224);
    chk("b2b1_len", 32'(len), 32'd30);
    chk("b2b1_busy", 32'(nb), 32'd30);
    chk("b2b_ready", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("b2b_busy0", 32'(busy), 32'd1);
    capture(1, cap, len, nb);
    chk("b2b2_bits", 32'(cap), 32'h668);
    chk("b2b2_len", 32'(len), 32'd22);
    chk("b2b2_busy", 32'(nb), 32'd22);

    // reset at cycle 10 of a 40-cycle frame
    cfg_div = 16'd3; cfg_data_bits = 4'd8;
    cfg_parity = 2'b00;
    send(9'h0A5);
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_tx", 32'(tx), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_ready0", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_ready", 32'(s_ready), 32'd1);
    pulses = 0;
    lows   = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (frame_done) pulses++;
      if (!tx) lows++;
    end
    chk("abort_pulses", 32'(pulses), 32'd0);
    chk("abort_lows", 32'(lows), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
